// File: rtl/audio_sample_streamer.sv
// Sample-rate streamer between the SD-card audio FIFO and the PWM stage.
// A fractional accumulator produces the rate tick; each tick pops and converts one sample.
module audio_sample_streamer #(
    parameter int CLK_HZ    = 50000000,
    parameter int SAMPLE_HZ = 48000,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [3:0]        vol,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic              fifo_prog_full,
    output logic              fifo_rd_en,
    output logic              sample_tick,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              playing,
    output logic [15:0]       underrun_cnt
);

    localparam int ACC_W = $clog2(CLK_HZ + SAMPLE_HZ);
    localparam logic [DATA_W-1:0] SILENCE = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t            state_r;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  acc_sum_s;
    logic [ACC_W-1:0]  acc_next_s;
    logic              tick_s;
    logic              cap_r;
    logic              sil1_r;
    logic              sil2_r;

    // Attenuate by arithmetic shift, then flip the sign bit for offset-binary.
    function automatic logic [DATA_W-1:0] to_offset_binary(
        input logic [DATA_W-1:0] d,
        input logic [3:0]        sh
    );
        logic signed [DATA_W-1:0] s;
        s = $signed(d) >>> sh;
        return {~s[DATA_W-1], s[DATA_W-2:0]};
    endfunction

    // Fractional rate accumulator: wrap by CLK_HZ and flag a tick on each wrap.
    always_comb begin
        acc_sum_s  = acc_r + ACC_W'(SAMPLE_HZ);
        acc_next_s = acc_sum_s;
        tick_s     = 1'b0;
        if (acc_sum_s >= ACC_W'(CLK_HZ)) begin
            acc_next_s = acc_sum_s - ACC_W'(CLK_HZ);
            tick_s     = 1'b1;
        end else begin
            acc_next_s = acc_sum_s;
            tick_s     = 1'b0;
        end
    end

    // Accumulator and registered tick run in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r       <= {ACC_W{1'b0}};
            sample_tick <= 1'b0;
        end else begin
            acc_r       <= acc_next_s;
            sample_tick <= tick_s;
        end
    end

    // Playback FSM with a two-stage output pipeline: tick -> read/capture -> output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            fifo_rd_en   <= 1'b0;
            cap_r        <= 1'b0;
            sil1_r       <= 1'b0;
            sil2_r       <= 1'b0;
            sample_out   <= SILENCE;
            sample_valid <= 1'b0;
            playing      <= 1'b0;
            underrun_cnt <= 16'h0000;
        end else begin
            fifo_rd_en   <= 1'b0;
            sample_valid <= 1'b0;
            sil1_r       <= 1'b0;
            // Pipeline stages die as soon as enable drops, so a popped word is discarded.
            cap_r        <= fifo_rd_en & enable;
            sil2_r       <= sil1_r & enable;
            if (!enable) begin
                state_r    <= IDLE;
                playing    <= 1'b0;
                sample_out <= SILENCE;
            end else begin
                if (cap_r) begin
                    sample_out   <= to_offset_binary(fifo_dout, vol);
                    sample_valid <= 1'b1;
                end else if (sil2_r) begin
                    sample_out   <= SILENCE;
                    sample_valid <= 1'b1;
                end else begin
                    sample_out   <= sample_out;
                end
                case (state_r)
                    IDLE: begin
                        state_r    <= PRIME;
                        playing    <= 1'b0;
                        sample_out <= SILENCE;
                    end
                    PRIME: begin
                        if (tick_s) begin
                            sil1_r <= 1'b1;
                        end else begin
                            sil1_r <= 1'b0;
                        end
                        if (fifo_prog_full) begin
                            state_r <= PLAY;
                            playing <= 1'b1;
                        end else begin
                            state_r <= PRIME;
                            playing <= 1'b0;
                        end
                    end
                    PLAY: begin
                        if (tick_s && !fifo_empty) begin
                            fifo_rd_en <= ~(fifo_rd_en | cap_r);
                        end else if (tick_s) begin
                            sil1_r       <= 1'b1;
                            underrun_cnt <= (underrun_cnt == 16'hFFFF) ? underrun_cnt
                                                                       : underrun_cnt + 16'h0001;
                            state_r      <= PRIME;
                            playing      <= 1'b0;
                        end else begin
                            state_r <= PLAY;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        playing <= 1'b0;
                    end
                endcase
            end
        end
    end

    audio_sample_streamer_chk #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ)
    ) u_chk (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick_s),
        .fifo_rd_en (fifo_rd_en),
        .cap        (cap_r)
    );

endmodule

// Checker: rate constraint and single-read-in-flight.
module audio_sample_streamer_chk #(
    parameter int CLK_HZ    = 50000000,
    parameter int SAMPLE_HZ = 48000
) (
    input logic clk,
    input logic reset_n,
    input logic tick,
    input logic fifo_rd_en,
    input logic cap
);

    localparam bit RATE_OK = (64'(SAMPLE_HZ) * 64'd3) < 64'(CLK_HZ);

    a_rate_ok: assert property (@(posedge clk) disable iff (!reset_n) RATE_OK);

    a_one_in_flight: assert property (@(posedge clk) disable iff (!reset_n)
        !(tick && (fifo_rd_en || cap)));

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Directed self-checking bench for audio_sample_streamer (default parameters).
module tb_audio_sample_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [3:0]  vol;
    logic [15:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_prog_full;
    logic        fifo_rd_en;
    logic        sample_tick;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        playing;
    logic [15:0] underrun_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] din;
        logic [3:0]  vol;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[7];

    audio_sample_streamer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .vol            (vol),
        .fifo_dout      (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_prog_full (fifo_prog_full),
        .fifo_rd_en     (fifo_rd_en),
        .sample_tick    (sample_tick),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .playing        (playing),
        .underrun_cnt   (underrun_cnt)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick(input string name);
        for (int i = 0; i < 2200; i++) begin
            @(negedge clk);
            if (sample_tick) return;
        end
        checks++;
        errors++;
        $display("FAIL %s tick timeout", name);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int  n;
        int  k;
        longint exp_pos;

        vecs[0] = '{16'h0000, 4'd0,  16'h8000};
        vecs[1] = '{16'h7FFF, 4'd0,  16'hFFFF};
        vecs[2] = '{16'h8000, 4'd0,  16'h0000};
        vecs[3] = '{16'hFFFF, 4'd0,  16'h7FFF};
        vecs[4] = '{16'h4000, 4'd1,  16'hA000};
        vecs[5] = '{16'h8000, 4'd2,  16'h6000};
        vecs[6] = '{16'h8000, 4'd15, 16'h7FFF};

        reset_n = 1'b0; enable = 1'b0; vol = 4'd0; fifo_dout = 16'h0000;
        fifo_empty = 1'b0; fifo_prog_full = 1'b0;
        wait_cycles(3);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_tick", {31'd0, sample_tick}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_playing", {31'd0, playing}, 32'd0);
        check("rst_out", {16'd0, sample_out}, 32'h8000);
        check("rst_urcnt", {16'd0, underrun_cnt}, 32'd0);

        // Tick positions: k-th tick lands on edge ceil(k*CLK_HZ/SAMPLE_HZ).
        reset_n = 1'b1;
        n = 0;
        k = 1;
        for (int i = 0; i < 6000 && k <= 5; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (sample_tick) begin
                exp_pos = (longint'(k) * 64'd50000000 + 64'd47999) / 64'd48000;
                check("tick_pos", n, exp_pos[31:0]);
                k++;
            end
        end
        if (k <= 5) begin
            checks++; errors++;
            $display("FAIL tick_pos only %0d ticks seen", k - 1);
        end

        // Priming: three ticks of silence without reads.
        enable = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_tick("prime_tick");
            check("prime_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            wait_cycles(2);
            check("prime_valid", {31'd0, sample_valid}, 32'd1);
            check("prime_out", {16'd0, sample_out}, 32'h8000);
            check("prime_playing", {31'd0, playing}, 32'd0);
        end
        fifo_prog_full = 1'b1;
        wait_cycles(1);
        check("play_entry", {31'd0, playing}, 32'd1);
        fifo_prog_full = 1'b0;

        // Conversion and volume vectors.
        for (int v = 0; v < 7; v++) begin
            fifo_dout = vecs[v].din;
            vol = vecs[v].vol;
            wait_tick("vec_tick");
            check("vec_rd_T", {31'd0, fifo_rd_en}, 32'd1);
            wait_cycles(1);
            check("vec_rd_width", {31'd0, fifo_rd_en}, 32'd0);
            check("vec_valid_T1", {31'd0, sample_valid}, 32'd0);
            wait_cycles(1);
            check("vec_valid_T2", {31'd0, sample_valid}, 32'd1);
            check("vec_out", {16'd0, sample_out}, {16'd0, vecs[v].exp});
        end
        vol = 4'd0;

        // Underrun.
        fifo_empty = 1'b1;
        wait_tick("ur_tick");
        check("ur_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("ur_cnt", {16'd0, underrun_cnt}, 32'd1);
        check("ur_playing", {31'd0, playing}, 32'd0);
        wait_cycles(2);
        check("ur_valid", {31'd0, sample_valid}, 32'd1);
        check("ur_out", {16'd0, sample_out}, 32'h8000);

        // Saturation from a preloaded count.
        force dut.underrun_cnt = 16'hFFFF;
        #1;
        release dut.underrun_cnt;
        fifo_prog_full = 1'b1;
        wait_cycles(2);
        check("resume_playing", {31'd0, playing}, 32'd1);
        fifo_prog_full = 1'b0;
        wait_tick("sat_tick");
        check("sat_cnt", {16'd0, underrun_cnt}, 32'hFFFF);
        check("sat_playing", {31'd0, playing}, 32'd0);

        // Abort: enable drops the cycle after the pop strobe.
        fifo_empty = 1'b0;
        fifo_prog_full = 1'b1;
        wait_cycles(2);
        fifo_dout = 16'h7FFF;
        wait_tick("pre_abort_tick");
        wait_cycles(2);
        check("pre_abort_out", {16'd0, sample_out}, 32'hFFFF);
        fifo_dout = 16'h1234;
        wait_tick("abort_tick");
        check("abort_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        wait_cycles(1);
        enable = 1'b0;
        wait_cycles(1);
        check("abort_valid", {31'd0, sample_valid}, 32'd0);
        check("abort_out", {16'd0, sample_out}, 32'h8000);
        check("abort_playing", {31'd0, playing}, 32'd0);
        wait_cycles(1);
        check("abort_valid2", {31'd0, sample_valid}, 32'd0);

        // Reset in the middle of a read.
        enable = 1'b1;
        wait_cycles(3);
        fifo_dout = 16'h7FFF;
        wait_tick("pre_rst_tick");
        wait_cycles(2);
        check("pre_rst_out", {16'd0, sample_out}, 32'hFFFF);
        wait_tick("rst_tick");
        check("mid_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("arst_tick", {31'd0, sample_tick}, 32'd0);
        check("arst_valid", {31'd0, sample_valid}, 32'd0);
        check("arst_playing", {31'd0, playing}, 32'd0);
        check("arst_out", {16'd0, sample_out}, 32'h8000);
        check("arst_urcnt", {16'd0, underrun_cnt}, 32'd0);
        wait_cycles(3);
        check("arst_hold_valid", {31'd0, sample_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sample_streamer.md
Name: audio_sample_streamer

Overview:
Downstream consumer of the SD-card audio FIFO and upstream feeder of the PWM audio stage.
- Generates an exact-average sample-rate tick from the 50 MHz audio clock using a fractional accumulator.
- Primes the FIFO before playback and pops one 16-bit sample per tick.
- Applies volume attenuation, converts signed PCM to offset-binary for the PWM, and handles underrun by emitting silence and re-priming.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- SAMPLE_HZ, 48000, output sample rate in Hz; must be < CLK_HZ.
- DATA_W, 16, sample width in bits.

Ports:
- clk  in  1  50 MHz audio clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  playback enable; low forces IDLE.
- vol  in  4  attenuation; arithmetic right shift of the signed sample by vol (0 = full scale, 15 = near silence).
- fifo_dout  in  DATA_W  FIFO read data, signed two's complement, valid one cycle after fifo_rd_en (standard, non-FWFT FIFO).
- fifo_empty  in  1  FIFO empty flag.
- fifo_prog_full  in  1  FIFO prime-threshold flag.
- fifo_rd_en  out  1  single-cycle FIFO pop strobe.
- sample_tick  out  1  one-cycle pulse at SAMPLE_HZ average rate.
- sample_out  out  DATA_W  unsigned offset-binary sample to the PWM stage.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- playing  out  1  high in PLAY state.
- underrun_cnt  out  16  saturating count of underrun events.

Behaviour:
- Reset values (reset_n low, async):
  - fifo_rd_en=0, sample_tick=0, sample_valid=0, playing=0, underrun_cnt=0.
  - sample_out=0x8000 (mid-scale silence), accumulator=0, state=IDLE, no read pending.
- Tick generator: runs in every state once reset is released.
  - acc_next = acc + SAMPLE_HZ.
  - If acc_next >= CLK_HZ: acc <= acc_next - CLK_HZ and sample_tick=1 for one cycle; else acc <= acc_next.
  - Accumulator width is ceil(log2(CLK_HZ+SAMPLE_HZ)).
  - With defaults, the first tick is on the 1042nd rising edge after reset release; exactly 48000 ticks occur per 50,000,000 cycles.
- States:
  - IDLE: sample_out held at 0x8000, no reads. enable=1 -> PRIME.
  - PRIME: wait for fifo_prog_full=1, then -> PLAY on the next cycle. Ticks in PRIME emit sample_out=0x8000 with a sample_valid pulse.
  - PLAY: playing=1. On a tick:
    - fifo_empty=0: fifo_rd_en=1 at cycle T; fifo_dout captured at T+1; sample_out and sample_valid=1 at T+2. Latency from tick to sample_valid is 2 cycles.
    - fifo_empty=1: underrun. No fifo_rd_en; sample_out=0x8000 with sample_valid at T+2; underrun_cnt += 1, saturating at 0xFFFF; -> PRIME.
- Arithmetic: s = signed(fifo_dout) >>> vol (sign-extending), then sample_out = {~s[DATA_W-1], s[DATA_W-2:0]}.
  - vol is sampled at the capture cycle.
- enable falls at any time -> IDLE on the next cycle and sample_out = 0x8000.
  - A read already strobed still pops the FIFO, but its data is discarded: no sample_valid for that word.
- fifo_rd_en is never asserted while fifo_empty=1, and never more than once per tick.
- At most one read is in flight at a time. A tick arriving while a read is in flight cannot occur for SAMPLE_HZ < CLK_HZ/3; this is a parameter constraint, checked by assertion.
- fifo_prog_full going low during PLAY has no effect; only empty at tick time causes an underrun.
- underrun_cnt clears only on reset.
- reset_n asserted mid-read: immediate return to all reset values; the pending read is abandoned.

Test Plan:
- Tick period: release reset and count cycles between sample_tick pulses -> first at cycle 1042; average over 50,000,000 cycles is exactly 48000 ticks; every interval is 1041 or 1042 cycles.
- Prime/play: enable=1, prog_full held low for 3 ticks -> three 0x8000 outputs and no rd_en; raise prog_full -> playing=1 next cycle.
- Conversion, vol=0: samples 0x0000, 0x7FFF, 0x8000, 0xFFFF -> sample_out 0x8000, 0xFFFF, 0x0000, 0x7FFF, each 2 cycles after its tick with rd_en exactly 1 cycle wide.
- Volume: vol=1, sample 0x4000 -> 0xA000; vol=2, sample 0x8000 -> 0x6000; vol=15, sample 0x8000 -> 0x7FFF.
- Underrun: empty=1 at a PLAY tick -> no rd_en, sample_out 0x8000, underrun_cnt 0->1, state PRIME, playing=0; preload 0xFFFF and force one more underrun -> count stays 0xFFFF.
- Abort: drop enable in the cycle after rd_en -> no sample_valid, sample_out 0x8000, IDLE; assert reset_n=0 mid-read -> all outputs at reset values asynchronously.
